sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
- FIFO controller directly upstream of the team's single-port synchronous SRAM (8-bit Addr, CS/WE/RD strobes, registered dataOut).
- Presents a push/pop FIFO interface to the producer and consumer, and generates every SRAM strobe and address.
- Tracks write/read pointers, occupancy and full/empty, arbitrates the single SRAM port, and returns read data with fixed 1-cycle latency.

Parameters:
- DATA_W, 8, data width; must equal the SRAM word width.
- ADDR_W, 8, SRAM address width.
- DEPTH, 8, number of usable SRAM words; 2 <= DEPTH <= 2^ADDR_W; need not be a power of two.
- CNT_W, 4, occupancy counter width; must hold DEPTH (ceil(log2(DEPTH+1))).

Ports:
- Clk  in  1  rising-edge clock, shared with the SRAM.
- Rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of FIFO contents.
- push_valid  in  1  producer has a word.
- push_data  in  DATA_W  word to store.
- push_ready  out  1  push accepted this cycle when push_valid && push_ready.
- pop_req  in  1  consumer requests one word.
- pop_valid  out  1  pop_data valid this cycle (1-cycle pulse).
- pop_data  out  DATA_W  read word, driven from sram_dataOut.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CNT_W  current occupancy.
- sram_Addr  out  ADDR_W  SRAM address.
- sram_CS  out  1  SRAM chip select.
- sram_WE  out  1  SRAM write strobe.
- sram_RD  out  1  SRAM read strobe.
- sram_dataIn  out  DATA_W  SRAM write data.
- sram_dataOut  in  DATA_W  SRAM registered read data.

Behaviour:
- Reset (Rst=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, pop_valid=0.
- While Rst=1: push_ready=0, and sram_CS/WE/RD=0 combinationally; no SRAM access is issued.
- After reset: empty=1, full=0, count=0, sram_Addr=0, sram_dataIn=0.
- Command selection is combinational, evaluated each cycle in this priority order:
  - Rst or flush: no access.
  - do_pop = pop_req && !empty.
  - do_push = push_valid && !full && !do_pop.
- Single SRAM port: pop wins over push when both are requested.
  - push_ready = !Rst && !flush && !full && !(pop_req && !empty).
- Write cycle (do_push):
  - Outputs: sram_CS=1, sram_WE=1, sram_RD=0, sram_Addr=wr_ptr (zero-extended), sram_dataIn=push_data.
  - At the edge: wr_ptr advances; count+1.
- Read cycle (do_pop):
  - Outputs: sram_CS=1, sram_RD=1, sram_WE=0, sram_Addr=rd_ptr.
  - At the edge: rd_ptr advances; count-1; pop_valid<=1.
- Idle cycle: CS=WE=RD=0. sram_Addr and sram_dataIn are don't-care; drive them 0.
- WE and RD are never both 1.
- Read latency: pop accepted in cycle N gives pop_valid=1 in cycle N+1, with pop_data=sram_dataOut (the word written at rd_ptr(N)).
  - pop_valid is cleared at the next edge unless another pop is accepted.
  - Back-to-back pops give consecutive pop_valid cycles.
- Pointer wrap: ptr == DEPTH-1 advances to 0. Pointers span 0..DEPTH-1 only.
- Full/empty are derived from count, never from pointer comparison.
- Write-then-read: a word pushed in cycle N may be popped in cycle N+1. The SRAM write completes at edge N, so no bypass is needed.
- Pop when empty: ignored. No strobe, pop_valid stays 0, count unchanged.
- Push when full: push_ready=0, no strobe, no state change.
- Flush (or Rst) mid-operation:
  - Pointers and count go to 0 and pop_valid<=0.
  - A pop accepted in the preceding cycle still produces its pop_valid in the flush cycle; the flush then clears it.
  - SRAM contents are not cleared.
- No overflow or underflow of count is possible under these rules. An assertion checks 0 <= count <= DEPTH.

Test Plan:
- Reset then idle: Rst=1 for 2 cycles, then release -> count=0, empty=1, full=0, push_ready=1, pop_valid=0, all SRAM strobes 0.
- Fill and drain, DEPTH=8: push 0x11..0x18 in consecutive cycles -> sram_Addr 0..7 with WE=1; full=1 and push_ready=0 after the 8th. Then pop 8 times -> RD at Addr 0..7, pop_valid on cycles N+1 with data 0x11..0x18 in order; empty=1 at the end.
- Wrap-around: push 6, pop 6, then push 0xA0..0xA4 -> writes land at Addr 6,7,0,1,2. Five pops return 0xA0..0xA4 in order; count returns to 0.
- Simultaneous push/pop at count=3: pop_req=1, push_valid=1 -> RD issued, push_ready=0, count=2. Next cycle push accepted once pop_req drops. Pop_req with empty=1 -> no RD, pop_valid stays 0.
- Push to empty in cycle N, pop in cycle N+1 -> pop_valid in N+2 with the pushed value (0x5A).
- Flush mid-stream: count=5, pop accepted in cycle N, flush=1 in N+1 -> pop_valid=1 with the correct word in N+1, then count=0, empty=1, pop_valid=0 in N+2. A subsequent push writes Addr 0. Repeat with Rst in place of flush and expect the same result.

Source files
------------

// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: producer/consumer handshake and SRAM bus bundle for sram_fifo_ctrl
// slave modport: the controller's view (takes push/pop/flush and sram_dataOut, drives status and SRAM strobes)
// master modport: the surrounding logic's view (opposite directions)
interface sram_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W = 4
);
  logic flush, push_valid, push_ready, pop_req, pop_valid, full, empty;
  logic [DATA_W-1:0] push_data, pop_data, sram_dataIn, sram_dataOut;
  logic [CNT_W-1:0] count;
  logic [ADDR_W-1:0] sram_Addr;
  logic sram_CS, sram_WE, sram_RD;
  modport master(
    output flush, push_valid, push_data, pop_req, sram_dataOut,
    input push_ready, pop_valid, pop_data, full, empty, count, sram_Addr, sram_CS, sram_WE, sram_RD, sram_dataIn
  );
  modport slave(
    input flush, push_valid, push_data, pop_req, sram_dataOut,
    output push_ready, pop_valid, pop_data, full, empty, count, sram_Addr, sram_CS, sram_WE, sram_RD, sram_dataIn
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller driving a single-port synchronous SRAM
// Clk/Rst: clock shared with the SRAM, synchronous active-high reset
// bus (slave): push/pop handshake, flush, full/empty/count status, SRAM Addr/CS/WE/RD/dataIn out, dataOut in
module sram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic Clk,
  input logic Rst,
  sram_fifo_ctrl_if.slave bus
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic pv, full, empty, idle, do_pop, do_push;
  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] p);
    return p == ADDR_W'(DEPTH - 1) ? '0 : p + ADDR_W'(1);
  endfunction
  assign full = cnt == CNT_W'(DEPTH);
  assign empty = cnt == '0;
  assign idle = Rst || bus.flush;
  // the single SRAM port goes to a pop whenever one is possible; push waits
  assign do_pop = !idle && bus.pop_req && !empty;
  assign do_push = !idle && bus.push_valid && !full && !do_pop;
  assign bus.push_ready = !idle && !full && !(bus.pop_req && !empty);
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.count = cnt;
  assign bus.pop_valid = pv;
  assign bus.pop_data = bus.sram_dataOut;
  assign bus.sram_CS = do_push || do_pop;
  assign bus.sram_WE = do_push;
  assign bus.sram_RD = do_pop;
  assign bus.sram_Addr = do_push ? wr_ptr : do_pop ? rd_ptr : '0;
  assign bus.sram_dataIn = do_push ? bus.push_data : DATA_W'(0);
  always_ff @(posedge Clk) begin
    if (idle) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      pv <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop) rd_ptr <= inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      pv <= do_pop;
    end
  end
  always_ff @(posedge Clk) if (!Rst) assert (cnt <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed plus randomized check of sram_fifo_ctrl against a queue-based FIFO model
module tb_sram_fifo_ctrl;
  localparam int DW = 8, AW = 8, D = 8, CW = 4;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;
  sram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus();
  sram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .CNT_W(CW)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  logic [DW-1:0] mem [256];
  always @(posedge Clk) begin
    if (bus.sram_CS && bus.sram_WE) mem[bus.sram_Addr] <= bus.sram_dataIn;
    if (bus.sram_CS && bus.sram_RD) bus.sram_dataOut <= mem[bus.sram_Addr];
  end
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  logic [DW-1:0] q[$];
  int wa = 0, ra = 0;
  logic epv = 1'b0;
  logic [DW-1:0] epd = '0;
  bit armed = 0;
  initial forever begin
    bit pop, push;
    @(negedge Clk);
    pop = !Rst && !bus.flush && bus.pop_req && q.size() > 0;
    push = !Rst && !bus.flush && bus.push_valid && q.size() < D && !pop;
    if (armed) begin
      chk("m_count", 32'(bus.count), q.size());
      chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("m_full", 32'(bus.full), 32'(q.size() == D));
      chk("m_push_ready", 32'(bus.push_ready), 32'(!Rst && !bus.flush && q.size() < D && !(bus.pop_req && q.size() > 0)));
      chk("m_cs", 32'(bus.sram_CS), 32'(pop || push));
      chk("m_we", 32'(bus.sram_WE), 32'(push));
      chk("m_rd", 32'(bus.sram_RD), 32'(pop));
      chk("m_addr", 32'(bus.sram_Addr), push ? wa : pop ? ra : 0);
      if (push) chk("m_data_in", 32'(bus.sram_dataIn), 32'(bus.push_data));
      chk("m_pop_valid", 32'(bus.pop_valid), 32'(epv));
      if (epv) chk("m_pop_data", 32'(bus.pop_data), 32'(epd));
    end
    if (Rst || bus.flush) begin
      q.delete();
      wa = 0;
      ra = 0;
      epv = 1'b0;
      armed = 1;
    end else begin
      epv = pop;
      if (pop) begin
        epd = q.pop_front();
        ra = (ra + 1) % D;
      end
      if (push) begin
        q.push_back(bus.push_data);
        wa = (wa + 1) % D;
      end
    end
  end
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic set(input logic pv, input logic [DW-1:0] pd, input logic pr, input logic fl);
    bus.push_valid = pv;
    bus.push_data = pd;
    bus.pop_req = pr;
    bus.flush = fl;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    set(0, 0, 0, 0);
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ready", 32'(bus.push_ready), 1);
    chk("rst_pv", 32'(bus.pop_valid), 0);
    chk("rst_cs", 32'({bus.sram_CS, bus.sram_WE, bus.sram_RD}), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      set(1, 8'h11 + 8'(i), 0, 0);
      @(negedge Clk);
      chk("fill_addr", 32'(bus.sram_Addr), i);
      chk("fill_we", 32'(bus.sram_WE), 1);
      tick();
    end
    set(1, 8'h99, 0, 0);
    @(negedge Clk);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_ready", 32'(bus.push_ready), 0);
    chk("full_count", 32'(bus.count), 8);
    chk("full_cs", 32'(bus.sram_CS), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      set(0, 0, 1, 0);
      @(negedge Clk);
      chk("drain_addr", 32'(bus.sram_Addr), i);
      chk("drain_rd", 32'(bus.sram_RD), 1);
      if (i > 0) chk("drain_data", 32'(bus.pop_data), 32'h11 + i - 1);
      tick();
    end
    set(0, 0, 0, 0);
    @(negedge Clk);
    chk("drain_last", 32'(bus.pop_data), 32'h18);
    chk("drain_pv", 32'(bus.pop_valid), 1);
    chk("drain_empty", 32'(bus.empty), 1);
    tick();
    for (int i = 0; i < 6; i++) begin set(1, 8'(i), 0, 0); tick(); end
    for (int i = 0; i < 6; i++) begin set(0, 0, 1, 0); tick(); end
    for (int i = 0; i < 5; i++) begin
      set(1, 8'hA0 + 8'(i), 0, 0);
      @(negedge Clk);
      chk("wrap_addr", 32'(bus.sram_Addr), (6 + i) % 8);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      set(0, 0, 1, 0);
      @(negedge Clk);
      if (i > 0) chk("wrap_data", 32'(bus.pop_data), 32'hA0 + i - 1);
      tick();
    end
    set(0, 0, 0, 0);
    @(negedge Clk);
    chk("wrap_last", 32'(bus.pop_data), 32'hA4);
    chk("wrap_count", 32'(bus.count), 0);
    tick();
    for (int i = 0; i < 3; i++) begin set(1, 8'h31 + 8'(i), 0, 0); tick(); end
    set(1, 8'h34, 1, 0);
    @(negedge Clk);
    chk("sim_rd", 32'(bus.sram_RD), 1);
    chk("sim_ready", 32'(bus.push_ready), 0);
    chk("sim_we", 32'(bus.sram_WE), 0);
    tick();
    set(1, 8'h34, 0, 0);
    @(negedge Clk);
    chk("sim_count", 32'(bus.count), 2);
    chk("sim_we2", 32'(bus.sram_WE), 1);
    chk("sim_data", 32'(bus.pop_data), 32'h31);
    tick();
    for (int i = 0; i < 3; i++) begin set(0, 0, 1, 0); tick(); end
    @(negedge Clk);
    chk("ue_empty", 32'(bus.empty), 1);
    chk("ue_rd", 32'(bus.sram_RD), 0);
    chk("ue_last", 32'(bus.pop_data), 32'h34);
    tick();
    @(negedge Clk);
    chk("ue_pv", 32'(bus.pop_valid), 0);
    chk("ue_count", 32'(bus.count), 0);
    tick();
    set(1, 8'h5A, 0, 0);
    tick();
    set(0, 0, 1, 0);
    tick();
    set(0, 0, 0, 0);
    @(negedge Clk);
    chk("wtr_pv", 32'(bus.pop_valid), 1);
    chk("wtr_data", 32'(bus.pop_data), 32'h5A);
    tick();
    for (int i = 0; i < 5; i++) begin set(1, 8'hC0 + 8'(i), 0, 0); tick(); end
    set(0, 0, 1, 0);
    tick();
    set(0, 0, 0, 1);
    @(negedge Clk);
    chk("fl_pv", 32'(bus.pop_valid), 1);
    chk("fl_data", 32'(bus.pop_data), 32'hC0);
    chk("fl_cs", 32'(bus.sram_CS), 0);
    tick();
    set(0, 0, 0, 0);
    @(negedge Clk);
    chk("fl_count", 32'(bus.count), 0);
    chk("fl_empty", 32'(bus.empty), 1);
    chk("fl_pv2", 32'(bus.pop_valid), 0);
    tick();
    set(1, 8'h77, 0, 0);
    @(negedge Clk);
    chk("fl_addr", 32'(bus.sram_Addr), 0);
    chk("fl_we", 32'(bus.sram_WE), 1);
    tick();
    for (int i = 0; i < 4; i++) begin set(1, 8'hD0 + 8'(i), 0, 0); tick(); end
    set(0, 0, 1, 0);
    tick();
    set(0, 0, 0, 0);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rs_pv", 32'(bus.pop_valid), 1);
    chk("rs_data", 32'(bus.pop_data), 32'h77);
    chk("rs_ready", 32'(bus.push_ready), 0);
    tick();
    Rst = 1'b0;
    @(negedge Clk);
    chk("rs_count", 32'(bus.count), 0);
    chk("rs_empty", 32'(bus.empty), 1);
    chk("rs_pv2", 32'(bus.pop_valid), 0);
    tick();
    set(1, 8'h88, 0, 0);
    @(negedge Clk);
    chk("rs_addr", 32'(bus.sram_Addr), 0);
    tick();
    for (int k = 0; k < 3000; k++) begin
      int bias;
      bias = ((k / 300) % 2) != 0 ? 75 : 25;
      Rst = $urandom_range(0, 199) == 0;
      set($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) < (100 - bias), $urandom_range(0, 63) == 0);
      tick();
    end
    Rst = 1'b0;
    set(0, 0, 0, 0);
    tick();
    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
